// File: rtl/prog_tick_gen_if.sv
// Control/status bundle for prog_tick_gen: the controller drives the master side,
// the tick generator implements the slave side.
interface prog_tick_gen_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             enable;
    logic             mod_load;
    logic [WIDTH-1:0] mod_value;
    logic             mode_in;
    logic             start;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             load_pending;
    logic [WIDTH-1:0] mod_active;

    modport master (
        output enable, mod_load, mod_value, mode_in, start,
        input  tick, count, busy, load_pending, mod_active
    );

    modport slave (
        input  enable, mod_load, mod_value, mode_in, start,
        output tick, count, busy, load_pending, mod_active
    );
endinterface

// File: rtl/prog_tick_gen.sv
// Runtime-programmable tick generator: modulo counter with a shadowed modulo/mode
// that is applied only at period boundaries; periodic or start-armed one-shot.
module prog_tick_gen #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_MOD = 50000,
    parameter bit          DEFAULT_OS  = 1'b0
) (
    input logic            clock_i,
    input logic            sreset_i,
    prog_tick_gen_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [WIDTH-1:0] DefMod   = WIDTH'(DEFAULT_MOD);
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);
    localparam state_e           DefState = DEFAULT_OS ? StIdle : StRun;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             tick_q;
    logic [WIDTH-1:0] mod_active_q;
    logic             mode_q;
    logic [WIDTH-1:0] shadow_mod_q;
    logic             shadow_mode_q;
    logic             pending_q;

    logic             mod_zero;
    logic             terminal;
    logic             apply;
    logic [WIDTH-1:0] new_mod;
    logic             new_mode;

    // A strobe coinciding with an apply point takes effect on that same edge.
    always_comb begin
        mod_zero = (mod_active_q == '0);
        terminal = (state_q == StRun) && bus.enable && !mod_zero
                   && (count_q == (mod_active_q - One));
        new_mod  = bus.mod_load ? bus.mod_value : shadow_mod_q;
        new_mode = bus.mod_load ? bus.mode_in : shadow_mode_q;
        apply    = (bus.mod_load || pending_q)
                   && (terminal || (state_q == StIdle) || mod_zero);
    end

    always_ff @(posedge clock_i) begin
        if (sreset_i) begin
            state_q       <= DefState;
            count_q       <= '0;
            tick_q        <= 1'b0;
            mod_active_q  <= DefMod;
            mode_q        <= DEFAULT_OS;
            shadow_mod_q  <= DefMod;
            shadow_mode_q <= DEFAULT_OS;
            pending_q     <= 1'b0;
        end else begin
            if (bus.mod_load) begin
                shadow_mod_q  <= bus.mod_value;
                shadow_mode_q <= bus.mode_in;
                pending_q     <= 1'b1;
            end
            if (apply) begin
                mod_active_q <= new_mod;
                mode_q       <= new_mode;
                pending_q    <= 1'b0;
                count_q      <= '0;
                // The terminal tick still belongs to the period of the old modulo.
                tick_q       <= terminal;
                if (!new_mode) begin
                    state_q <= StRun;
                end else if (state_q == StIdle) begin
                    state_q <= bus.start ? StRun : StIdle;
                end else if (terminal) begin
                    state_q <= StIdle;
                end
            end else begin
                tick_q <= 1'b0;
                case (state_q)
                    StIdle: begin
                        count_q <= '0;
                        if (bus.start && mode_q) begin
                            state_q <= StRun;
                        end
                    end
                    StRun: begin
                        if (bus.enable && !mod_zero) begin
                            if (terminal) begin
                                tick_q  <= 1'b1;
                                count_q <= '0;
                                if (mode_q) begin
                                    state_q <= StIdle;
                                end
                            end else begin
                                count_q <= count_q + One;
                            end
                        end
                    end
                    default: state_q <= DefState;
                endcase
            end
        end
    end

    assign bus.tick         = tick_q;
    assign bus.count        = count_q;
    assign bus.busy         = (state_q == StRun);
    assign bus.load_pending = pending_q;
    assign bus.mod_active   = mod_active_q;

endmodule

// File: tb/tb_prog_tick_gen.sv
// Directed vector bench for prog_tick_gen (WIDTH=16, DEFAULT_MOD=5, periodic reset mode).
module tb_prog_tick_gen;

    typedef struct {
        logic        sr;
        logic        en;
        logic        ld;
        logic [15:0] val;
        logic        md;
        logic        st;
        logic        tk;
        logic [15:0] cnt;
        logic        bsy;
        logic        pnd;
        logic [15:0] ma;
    } vec_t;

    logic clk = 1'b0;
    logic sreset;
    int   total  = 0;
    int   passes = 0;
    vec_t vecs[$];

    prog_tick_gen_if #(.WIDTH(16)) bus_if ();

    prog_tick_gen #(
        .WIDTH      (16),
        .DEFAULT_MOD(5),
        .DEFAULT_OS (1'b0)
    ) dut (
        .clock_i (clk),
        .sreset_i(sreset),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic add(input logic sr, input logic en, input logic ld, input int val,
                       input logic md, input logic st, input logic tk, input int cnt,
                       input logic bsy, input logic pnd, input int ma);
        vec_t v;
        v.sr  = sr;
        v.en  = en;
        v.ld  = ld;
        v.val = 16'(val);
        v.md  = md;
        v.st  = st;
        v.tk  = tk;
        v.cnt = 16'(cnt);
        v.bsy = bsy;
        v.pnd = pnd;
        v.ma  = 16'(ma);
        vecs.push_back(v);
    endtask

    // Steps until tick is seen (bounded); n is the number of edges taken.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus_if.tick && n < 50);
    endtask

    initial begin
        int n;
        int en_pat [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        int cnt_pat[8] = '{1, 1, 2, 2, 3, 3, 0, 0};

        sreset            = 1'b1;
        bus_if.enable     = 1'b0;
        bus_if.mod_load   = 1'b0;
        bus_if.mod_value  = '0;
        bus_if.mode_in    = 1'b0;
        bus_if.start      = 1'b0;

        // Reset, then free-running mod 5
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5);
        for (int k = 1; k <= 15; k++) add(0, 1, 0, 0, 0, 0, (k % 5) == 0, k % 5, 1, 0, 5);
        // Load 3 mid-period: current period completes, then every 3
        add(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 5);
        add(0, 1, 1, 3, 0, 0, 0, 2, 1, 1, 5);
        add(0, 1, 0, 0, 0, 0, 0, 3, 1, 1, 5);
        add(0, 1, 0, 0, 0, 0, 0, 4, 1, 1, 5);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 3);
        for (int k = 1; k <= 6; k++) add(0, 1, 0, 0, 0, 0, (k % 3) == 0, k % 3, 1, 0, 3);
        // Switch to mod 4, then toggle enable
        add(0, 1, 1, 4, 0, 0, 0, 1, 1, 1, 3);
        add(0, 1, 0, 0, 0, 0, 0, 2, 1, 1, 3);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 4);
        for (int k = 0; k < 8; k++)
            add(0, 1'(en_pat[k]), 0, 0, 0, 0, k == 6, cnt_pat[k], 1, 0, 4);
        // Switch to one-shot mod 4; start, ignored start in RUN, restart
        add(0, 1, 1, 4, 1, 0, 0, 1, 1, 1, 4);
        add(0, 1, 0, 0, 0, 0, 0, 2, 1, 1, 4);
        add(0, 1, 0, 0, 0, 0, 0, 3, 1, 1, 4);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        add(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 4);
        add(0, 1, 0, 0, 0, 1, 0, 2, 1, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 3, 1, 0, 4);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        add(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 3, 1, 0, 4);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4);
        // Start together with a one-shot apply in IDLE uses the new modulo
        add(0, 1, 1, 2, 1, 1, 0, 0, 1, 0, 2);
        add(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2);
        add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2);
        // Modulo 1, then 0, then 2
        add(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 1, 2, 0, 0, 0, 0, 1, 0, 2);
        for (int k = 1; k <= 4; k++) add(0, 1, 0, 0, 0, 0, (k % 2) == 0, k % 2, 1, 0, 2);
        // Mod 6, reset at count 3 with a load pending
        add(0, 1, 1, 6, 0, 0, 0, 1, 1, 1, 2);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 6);
        add(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 6);
        add(0, 1, 1, 9, 0, 0, 0, 2, 1, 1, 6);
        add(0, 1, 0, 0, 0, 0, 0, 3, 1, 1, 6);
        add(1, 1, 1, 7, 1, 1, 0, 0, 1, 0, 5);
        for (int k = 1; k <= 5; k++) add(0, 1, 0, 0, 0, 0, (k % 5) == 0, k % 5, 1, 0, 5);
        // Last write wins, then a load coinciding with terminal
        add(0, 1, 1, 8, 0, 0, 0, 1, 1, 1, 5);
        add(0, 1, 1, 3, 0, 0, 0, 2, 1, 1, 5);
        add(0, 1, 0, 0, 0, 0, 0, 3, 1, 1, 5);
        add(0, 1, 0, 0, 0, 0, 0, 4, 1, 1, 5);
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 3);
        add(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 3);
        add(0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 3);
        add(0, 1, 1, 4, 0, 0, 1, 0, 1, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 4);

        foreach (vecs[i]) begin
            sreset           = vecs[i].sr;
            bus_if.enable    = vecs[i].en;
            bus_if.mod_load  = vecs[i].ld;
            bus_if.mod_value = vecs[i].val;
            bus_if.mode_in   = vecs[i].md;
            bus_if.start     = vecs[i].st;
            step();
            check("tick", i, 32'(bus_if.tick), 32'(vecs[i].tk));
            check("count", i, 32'(bus_if.count), 32'(vecs[i].cnt));
            check("busy", i, 32'(bus_if.busy), 32'(vecs[i].bsy));
            check("load_pending", i, 32'(bus_if.load_pending), 32'(vecs[i].pnd));
            check("mod_active", i, 32'(bus_if.mod_active), 32'(vecs[i].ma));
        end

        // Free-running mod 4 from count 1: tick spacing and width
        sreset          = 1'b0;
        bus_if.enable   = 1'b1;
        bus_if.mod_load = 1'b0;
        bus_if.start    = 1'b0;
        wait_tick(n);
        check("first_tick_edges", 0, 32'(n), 32'd3);
        wait_tick(n);
        check("tick_period", 0, 32'(n), 32'd4);
        step();
        check("tick_width", 0, 32'(bus_if.tick), 32'd0);
        check("count_after_tick", 0, 32'(bus_if.count), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
